// File: rtl/mux2_rr_arbiter.sv
// Round-robin burst arbiter for a shared 2:1 mux, feeding a one-entry
// registered output stage with valid/ready backpressure.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] in0,
  input  logic             valid0,
  input  logic             last0,
  output logic             ready0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in1,
  input  logic             valid1,
  input  logic             last1,
  output logic             ready1,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t           state;
  logic             prio;
  logic [CNT_W-1:0] beat_cnt;

  logic             stage_open;
  logic             cur_valid;
  logic             cur_last;
  logic [WIDTH-1:0] cur_data;
  logic             xfer;
  logic             beat_last;

  // A burst ends on the producer's last flag or when it reaches MAX_BEATS.
  function automatic logic end_of_burst(input logic flag, input logic [CNT_W-1:0] cnt);
    return flag | (cnt == CNT_END);
  endfunction

  assign gnt0       = (state == BUSY0);
  assign gnt1       = (state == BUSY1);
  assign sel        = gnt1;
  assign stage_open = ~out_valid | out_ready;
  assign ready0     = gnt0 & stage_open;
  assign ready1     = gnt1 & stage_open;

  assign cur_valid  = sel ? valid1 : valid0;
  assign cur_last   = sel ? last1  : last0;
  assign cur_data   = sel ? in1    : in0;
  assign xfer       = (gnt0 | gnt1) & cur_valid & stage_open;
  assign beat_last  = end_of_burst(cur_last, beat_cnt);

  // Arbitration and output stage: grant is registered, so req never reaches gnt combinationally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 && req1) state <= prio ? BUSY1 : BUSY0;
          else if (req0)    state <= BUSY0;
          else if (req1)    state <= BUSY1;
        end
        BUSY0, BUSY1: begin
          if (xfer) begin
            if (beat_last) begin
              state    <= IDLE;
              prio     <= ~sel;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= cur_data;
        out_last  <= beat_last;
        out_src   <= sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
